// File: rtl/clint_trap_ctrl.sv
// clint_trap_ctrl: machine-mode trap sequencer driving the CSR file's
// secondary (clint) write port.
//
// Accepts ecall/ebreak/mret from EX and the level timer/external interrupt
// lines while idle. It then holds the pipeline and writes mepc, mcause and
// mstatus, one CSR per cycle. It finishes with a one-cycle PC redirect to
// mtvec (trap entry) or to mepc (mret).
//
// Ports
//   clk, rst              clock, asynchronous active-low reset
//   ecall_i/ebreak_i      synchronous trap requests from EX
//   mret_i                return-from-trap request from EX
//   inst_addr_i           PC of the instruction in EX
//   jump_flag_i/_addr_i   EX redirect and its target (interrupt return point)
//   int_flag_i[1:0]       level interrupts: [0] timer, [1] external
//   global_int_en_i       mstatus.MIE
//   csr_mtvec_i/_mepc_i/_mstatus_i  current CSR values
//   hold_o                pipeline stall
//   csr_we_o/_waddr_o/_data_o       CSR write port
//   int_assert_o/_addr_o  one-cycle PC redirect
module clint_trap_ctrl #(
  parameter logic [31:0] TIMER_CAUSE  = 32'h8000_0007,
  parameter logic [31:0] EXT_CAUSE    = 32'h8000_000B,
  parameter logic [31:0] ECALL_CAUSE  = 32'd11,
  parameter logic [31:0] EBREAK_CAUSE = 32'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic [1:0]  int_flag_i,
  input  logic        global_int_en_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        hold_o,
  output logic        csr_we_o,
  output logic [31:0] csr_waddr_o,
  output logic [31:0] csr_data_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    W_MSTATUS,
    T_JUMP,
    R_MSTATUS,
    R_JUMP
  } state_e;

  state_e      state_q;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        sync_req, int_req, accept;

  always_comb begin
    sync_req = ecall_i | ebreak_i;
    int_req  = global_int_en_i & (|int_flag_i);
    // Gated by rst so every output reads 0 while reset is asserted.
    accept   = rst & (state_q == IDLE) & (sync_req | mret_i | int_req);

    cause_d = EXT_CAUSE;
    if (ecall_i)            cause_d = ECALL_CAUSE;
    else if (ebreak_i)      cause_d = EBREAK_CAUSE;
    else if (int_flag_i[0]) cause_d = TIMER_CAUSE;

    // Interrupts resume at the instruction after EX, or at its branch target.
    if (sync_req)         epc_d = inst_addr_i;
    else if (jump_flag_i) epc_d = jump_addr_i;
    else                  epc_d = inst_addr_i + 32'd4;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sync_req || (!mret_i && int_req)) begin
            state_q <= W_MEPC;
            cause_q <= cause_d;
            epc_q   <= epc_d;
          end else if (mret_i) begin
            state_q <= R_MSTATUS;
          end
        end
        W_MEPC:    state_q <= W_MCAUSE;
        W_MCAUSE:  state_q <= W_MSTATUS;
        W_MSTATUS: state_q <= T_JUMP;
        R_MSTATUS: state_q <= R_JUMP;
        default:   state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    hold_o       = accept | (state_q != IDLE);
    csr_we_o     = 1'b0;
    csr_waddr_o  = '0;
    csr_data_o   = '0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    case (state_q)
      W_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_data_o  = epc_q;
      end
      W_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MCAUSE;
        csr_data_o  = cause_q;
      end
      W_MSTATUS: begin
        // MPIE <= MIE, MIE <= 0
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_data_o  = {csr_mstatus_i[31:8], csr_mstatus_i[3],
                       csr_mstatus_i[6:4], 1'b0, csr_mstatus_i[2:0]};
      end
      T_JUMP: begin
        int_assert_o = 1'b1;
        int_addr_o   = csr_mtvec_i;
      end
      R_MSTATUS: begin
        // MIE <= MPIE, MPIE <= 1
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_data_o  = {csr_mstatus_i[31:8], 1'b1,
                       csr_mstatus_i[6:4], csr_mstatus_i[7], csr_mstatus_i[2:0]};
      end
      R_JUMP: begin
        int_assert_o = 1'b1;
        int_addr_o   = csr_mepc_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_clint_trap_ctrl.sv
// Testbench for clint_trap_ctrl: directed scenarios plus randomized
// request traffic, each checked cycle by cycle against a sequence model.
module tb_clint_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ecall_i, ebreak_i, mret_i, jump_flag_i, global_int_en_i;
  logic [31:0] inst_addr_i, jump_addr_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic [1:0]  int_flag_i;
  logic        hold_o, csr_we_o, int_assert_o;
  logic [31:0] csr_waddr_o, csr_data_o, int_addr_o;

  int unsigned tests = 0;
  int unsigned fails = 0;

  typedef struct packed {
    logic        hold;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        ias;
    logic [31:0] iaddr;
  } obs_t;

  obs_t exp_q[$];

  clint_trap_ctrl #(
    .TIMER_CAUSE (32'h8000_0007),
    .EXT_CAUSE   (32'h8000_000B),
    .ECALL_CAUSE (32'd11),
    .EBREAK_CAUSE(32'd3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ecall_i        (ecall_i),
    .ebreak_i       (ebreak_i),
    .mret_i         (mret_i),
    .inst_addr_i    (inst_addr_i),
    .jump_flag_i    (jump_flag_i),
    .jump_addr_i    (jump_addr_i),
    .int_flag_i     (int_flag_i),
    .global_int_en_i(global_int_en_i),
    .csr_mtvec_i    (csr_mtvec_i),
    .csr_mepc_i     (csr_mepc_i),
    .csr_mstatus_i  (csr_mstatus_i),
    .hold_o         (hold_o),
    .csr_we_o       (csr_we_o),
    .csr_waddr_o    (csr_waddr_o),
    .csr_data_o     (csr_data_o),
    .int_assert_o   (int_assert_o),
    .int_addr_o     (int_addr_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic obs_t mk(input logic h, input logic we, input logic [31:0] wa,
                              input logic [31:0] wd, input logic ia, input logic [31:0] iad);
    obs_t o;
    o.hold = h; o.we = we; o.waddr = wa; o.wdata = wd; o.ias = ia; o.iaddr = iad;
    return o;
  endfunction

  function automatic obs_t observe();
    return mk(hold_o, csr_we_o, csr_waddr_o, csr_data_o, int_assert_o, int_addr_o);
  endfunction

  // mstatus after trap entry: MPIE takes the old MIE, MIE cleared.
  function automatic logic [31:0] ms_trap(input logic [31:0] m);
    logic [31:0] r;
    r = m & ~32'h88;
    if ((m & 32'h8) != 0) r = r | 32'h80;
    return r;
  endfunction

  // mstatus after mret: MIE takes the old MPIE, MPIE set.
  function automatic logic [31:0] ms_ret(input logic [31:0] m);
    logic [31:0] r;
    r = (m & ~32'h8) | 32'h80;
    if ((m & 32'h80) != 0) r = r | 32'h8;
    return r;
  endfunction

  // Appends the expected per-cycle outputs for one IDLE decision, made from
  // the bench's current input values, starting with the decision cycle.
  task automatic model_build();
    logic        trap;
    logic [31:0] cause, epc;
    trap = 1'b0; cause = '0; epc = '0;
    if (ecall_i) begin
      trap = 1'b1; cause = 32'd11; epc = inst_addr_i;
    end else if (ebreak_i) begin
      trap = 1'b1; cause = 32'd3; epc = inst_addr_i;
    end else if (mret_i) begin
      exp_q.push_back(mk(1'b1, 1'b0, '0, '0, 1'b0, '0));
      exp_q.push_back(mk(1'b1, 1'b1, 32'h300, ms_ret(csr_mstatus_i), 1'b0, '0));
      exp_q.push_back(mk(1'b1, 1'b0, '0, '0, 1'b1, csr_mepc_i));
      return;
    end else if (global_int_en_i && int_flag_i != 2'b00) begin
      trap  = 1'b1;
      cause = int_flag_i[0] ? 32'h8000_0007 : 32'h8000_000B;
      epc   = jump_flag_i ? jump_addr_i : inst_addr_i + 32'd4;
    end
    if (!trap) begin
      exp_q.push_back('0);
      return;
    end
    exp_q.push_back(mk(1'b1, 1'b0, '0, '0, 1'b0, '0));
    exp_q.push_back(mk(1'b1, 1'b1, 32'h341, epc, 1'b0, '0));
    exp_q.push_back(mk(1'b1, 1'b1, 32'h342, cause, 1'b0, '0));
    exp_q.push_back(mk(1'b1, 1'b1, 32'h300, ms_trap(csr_mstatus_i), 1'b0, '0));
    exp_q.push_back(mk(1'b1, 1'b0, '0, '0, 1'b1, csr_mtvec_i));
  endtask

  task automatic clear_req();
    ecall_i = 1'b0; ebreak_i = 1'b0; mret_i = 1'b0; int_flag_i = 2'b00;
  endtask

  task automatic test_reset();
    obs_t got;
    rst = 1'b0;
    clear_req();
    jump_flag_i = 1'b0; jump_addr_i = '0; inst_addr_i = '0; global_int_en_i = 1'b1;
    csr_mtvec_i = '0; csr_mepc_i = '0; csr_mstatus_i = '0;
    ecall_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = observe();
    tests++;
    if (got !== obs_t'('0)) begin
      fails++;
      $display("FAIL reset: got %h expected %h", got, obs_t'('0));
    end
    ecall_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // ecall at 0x100, mtvec 0x200, mstatus 0x8, values written out literally.
  task automatic test_ecall();
    obs_t got;
    @(posedge clk); #1;
    ecall_i = 1'b1; inst_addr_i = 32'h100; csr_mtvec_i = 32'h200;
    csr_mstatus_i = 32'h8; csr_mepc_i = 32'h0;
    exp_q.delete();
    exp_q.push_back(mk(1'b1, 1'b0, '0, '0, 1'b0, '0));
    exp_q.push_back(mk(1'b1, 1'b1, 32'h341, 32'h100, 1'b0, '0));
    exp_q.push_back(mk(1'b1, 1'b1, 32'h342, 32'd11, 1'b0, '0));
    exp_q.push_back(mk(1'b1, 1'b1, 32'h300, 32'h80, 1'b0, '0));
    exp_q.push_back(mk(1'b1, 1'b0, '0, '0, 1'b1, 32'h200));
    exp_q.push_back('0);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      got = observe();
      tests++;
      if (got !== exp_q[k]) begin
        fails++;
        $display("FAIL ecall[%0d]: got %h expected %h", k, got, exp_q[k]);
      end
      @(posedge clk); #1;
      if (k == 0) clear_req();
    end
  endtask

  // Timer interrupt, fall-through then taken-branch return point, then ebreak.
  task automatic test_interrupt();
    obs_t got;
    for (int v = 0; v < 3; v++) begin
      @(posedge clk); #1;
      global_int_en_i = 1'b1; csr_mstatus_i = 32'h8; inst_addr_i = 32'h40;
      jump_flag_i = (v == 1); jump_addr_i = 32'h80;
      if (v == 2) ebreak_i = 1'b1;
      else        int_flag_i = 2'b01;
      exp_q.delete();
      model_build();
      exp_q.push_back('0);
      for (int k = 0; k < exp_q.size(); k++) begin
        @(negedge clk);
        got = observe();
        tests++;
        if (got !== exp_q[k]) begin
          fails++;
          $display("FAIL interrupt%0d[%0d]: got %h expected %h", v, k, got, exp_q[k]);
        end
        @(posedge clk); #1;
        if (k == 0) clear_req();
      end
      jump_flag_i = 1'b0;
    end
  endtask

  // Both lines pending with MIE=0 are ignored; once enabled the timer wins.
  task automatic test_masked();
    obs_t got;
    @(posedge clk); #1;
    int_flag_i = 2'b11; global_int_en_i = 1'b0; csr_mstatus_i = 32'h0;
    inst_addr_i = 32'h1000; csr_mtvec_i = 32'h300;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      got = observe();
      tests++;
      if (got !== obs_t'('0)) begin
        fails++;
        $display("FAIL masked[%0d]: got %h expected %h", k, got, obs_t'('0));
      end
      @(posedge clk); #1;
    end
    global_int_en_i = 1'b1; csr_mstatus_i = 32'h8;
    exp_q.delete();
    model_build();
    exp_q.push_back('0);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      got = observe();
      tests++;
      if (got !== exp_q[k]) begin
        fails++;
        $display("FAIL unmasked[%0d]: got %h expected %h", k, got, exp_q[k]);
      end
      @(posedge clk); #1;
      if (k == 0) clear_req();
    end
  endtask

  // mret alone (literal values), then mret together with a pending timer.
  task automatic test_mret();
    obs_t got;
    @(posedge clk); #1;
    mret_i = 1'b1; csr_mstatus_i = 32'h80; csr_mepc_i = 32'h44; global_int_en_i = 1'b0;
    exp_q.delete();
    exp_q.push_back(mk(1'b1, 1'b0, '0, '0, 1'b0, '0));
    exp_q.push_back(mk(1'b1, 1'b1, 32'h300, 32'h88, 1'b0, '0));
    exp_q.push_back(mk(1'b1, 1'b0, '0, '0, 1'b1, 32'h44));
    exp_q.push_back('0);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      got = observe();
      tests++;
      if (got !== exp_q[k]) begin
        fails++;
        $display("FAIL mret[%0d]: got %h expected %h", k, got, exp_q[k]);
      end
      @(posedge clk); #1;
      if (k == 0) clear_req();
    end

    mret_i = 1'b1; int_flag_i = 2'b01; global_int_en_i = 1'b1;
    inst_addr_i = 32'h500; jump_flag_i = 1'b0; csr_mtvec_i = 32'h600;
    exp_q.delete();
    model_build();
    mret_i = 1'b0;
    model_build();
    exp_q.push_back('0);
    mret_i = 1'b1;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      got = observe();
      tests++;
      if (got !== exp_q[k]) begin
        fails++;
        $display("FAIL mret_int[%0d]: got %h expected %h", k, got, exp_q[k]);
      end
      @(posedge clk); #1;
      if (k == 0) mret_i = 1'b0;
      if (k == 3) clear_req();
    end
  endtask

  // Reset mid-sequence, then an interrupt whose return point wraps to 0.
  task automatic test_reset_mid();
    obs_t got;
    obs_t w;
    @(posedge clk); #1;
    ecall_i = 1'b1; inst_addr_i = 32'h100; csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h200;
    @(posedge clk); #1;
    clear_req();
    @(posedge clk); #1;
    @(negedge clk);
    got = observe();
    w = mk(1'b1, 1'b1, 32'h342, 32'd11, 1'b0, '0);
    tests++;
    if (got !== w) begin
      fails++;
      $display("FAIL pre_reset: got %h expected %h", got, w);
    end
    #2 rst = 1'b0;
    #1;
    got = observe();
    tests++;
    if (got !== obs_t'('0)) begin
      fails++;
      $display("FAIL mid_reset: got %h expected %h", got, obs_t'('0));
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    got = observe();
    tests++;
    if (got !== obs_t'('0)) begin
      fails++;
      $display("FAIL post_reset: got %h expected %h", got, obs_t'('0));
    end

    @(posedge clk); #1;
    int_flag_i = 2'b01; global_int_en_i = 1'b1; inst_addr_i = 32'hFFFF_FFFC;
    jump_flag_i = 1'b0; csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h200;
    exp_q.delete();
    exp_q.push_back(mk(1'b1, 1'b0, '0, '0, 1'b0, '0));
    exp_q.push_back(mk(1'b1, 1'b1, 32'h341, 32'h0, 1'b0, '0));
    exp_q.push_back(mk(1'b1, 1'b1, 32'h342, 32'h8000_0007, 1'b0, '0));
    exp_q.push_back(mk(1'b1, 1'b1, 32'h300, 32'h80, 1'b0, '0));
    exp_q.push_back(mk(1'b1, 1'b0, '0, '0, 1'b1, 32'h200));
    exp_q.push_back('0);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      got = observe();
      tests++;
      if (got !== exp_q[k]) begin
        fails++;
        $display("FAIL wrap[%0d]: got %h expected %h", k, got, exp_q[k]);
      end
      @(posedge clk); #1;
      if (k == 0) clear_req();
    end
  endtask

  // Random requests; while busy the request lines carry random noise that
  // must be ignored, and they are quiet again for the cycle back in IDLE.
  task automatic test_random();
    obs_t got;
    for (int it = 0; it < 60; it++) begin
      @(posedge clk); #1;
      ecall_i         = ($urandom_range(0, 9) < 2);
      ebreak_i        = ($urandom_range(0, 9) < 2);
      mret_i          = ($urandom_range(0, 9) < 3);
      int_flag_i      = 2'($urandom_range(0, 3));
      global_int_en_i = 1'($urandom);
      jump_flag_i     = 1'($urandom);
      inst_addr_i     = $urandom;
      jump_addr_i     = $urandom;
      csr_mstatus_i   = $urandom;
      csr_mtvec_i     = $urandom;
      csr_mepc_i      = $urandom;
      exp_q.delete();
      model_build();
      exp_q.push_back('0);
      for (int k = 0; k < exp_q.size(); k++) begin
        @(negedge clk);
        got = observe();
        tests++;
        if (got !== exp_q[k]) begin
          fails++;
          $display("FAIL random%0d[%0d]: got %h expected %h", it, k, got, exp_q[k]);
        end
        @(posedge clk); #1;
        if (k + 2 < exp_q.size()) begin
          ecall_i = 1'($urandom); ebreak_i = 1'($urandom); mret_i = 1'($urandom);
          int_flag_i = 2'($urandom); global_int_en_i = 1'($urandom);
          jump_flag_i = 1'($urandom); inst_addr_i = $urandom; jump_addr_i = $urandom;
        end else begin
          clear_req();
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ecall();
    test_interrupt();
    test_masked();
    test_mret();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
